riscv_wb_scheduler: RTL and testbench

- Owns the single write port of the 32x32 register file (regfile write on negedge clk, combinational reads; x0 not protected inside the regfile).
- Round-robin arbitrates writeback requests from NUM_SRC execution units (0=ALU, 1=LSU, 2=MDU) onto that port.
- Keeps a per-register busy scoreboard and raises issue_stall on RAW/WAW hazards against outstanding writes.
- Sits between decode/issue, the execution units and the register file.

---
 rtl/riscv_pkg.sv | 24 ++
 rtl/riscv_rr_arbiter.sv | 30 +++
 rtl/riscv_wb_scheduler.sv | 118 +++++++++++
 tb/tb_riscv_wb_scheduler.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared constants, source IDs and the register-mask helper used by the writeback
// scheduler and its arbiter.
package riscv_pkg;

  localparam int XLEN  = 32;
  localparam int AW    = 5;
  localparam int NREGS = 32;

  localparam int SRC_ALU = 0;
  localparam int SRC_LSU = 1;
  localparam int SRC_MDU = 2;

  // One-hot mask for a register; x0 maps to an empty mask so it never reads busy.
  function automatic logic [NREGS-1:0] reg_mask(input logic [AW-1:0] r);
    logic [NREGS-1:0] m;
    if (r == {AW{1'b0}}) begin
      m = {NREGS{1'b0}};
    end else begin
      m = {{(NREGS-1){1'b0}}, 1'b1} << r;
    end
    return m;
  endfunction

endpackage

// File: rtl/riscv_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or above ptr
// (modulo NUM_SRC) wins.
module riscv_rr_arbiter #(
  parameter int NUM_SRC = 3,
  parameter int PW      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_SRC-1:0] grant,
  output logic [PW-1:0]      idx,
  output logic               valid
);

  // Rotate the search start to ptr and latch onto the first request found.
  always_comb begin
    grant = {NUM_SRC{1'b0}};
    idx   = {PW{1'b0}};
    valid = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!valid && req[(int'(ptr) + k) % NUM_SRC]) begin
        grant[(int'(ptr) + k) % NUM_SRC] = 1'b1;
        idx   = PW'((int'(ptr) + k) % NUM_SRC);
        valid = 1'b1;
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/riscv_wb_scheduler.sv
// Writeback scheduler: arbitrates execution-unit results onto the single regfile
// write port and tracks outstanding destination registers for issue hazards.
module riscv_wb_scheduler #(
  parameter int NUM_SRC = 3,
  parameter int XLEN    = riscv_pkg::XLEN,
  parameter int AW      = riscv_pkg::AW
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    issue_valid,
  input  logic [AW-1:0]           issue_rs1,
  input  logic [AW-1:0]           issue_rs2,
  input  logic [AW-1:0]           issue_rd,
  input  logic                    issue_rd_we,
  output logic                    issue_stall,
  input  logic [NUM_SRC-1:0]      wb_valid,
  input  logic [NUM_SRC*AW-1:0]   wb_rd,
  input  logic [NUM_SRC*XLEN-1:0] wb_data,
  output logic [NUM_SRC-1:0]      wb_ready,
  output logic                    reg_write_en,
  output logic [AW-1:0]           rd,
  output logic [XLEN-1:0]         data_to_reg,
  output logic [31:0]             busy_vec,
  output logic                    sb_err
);
  import riscv_pkg::*;

  localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NREGS-1:0] busy_r;
  logic [NREGS-1:0] busy_next_s;
  logic [PW-1:0]    rr_ptr_r;
  logic [PW-1:0]    rr_ptr_next_s;
  logic             sb_err_r;
  logic             reg_write_en_r;
  logic [AW-1:0]    rd_r;
  logic [XLEN-1:0]  data_r;

  logic [NUM_SRC-1:0] grant_s;
  logic [PW-1:0]      gidx_s;
  logic               hs_s;
  logic [AW-1:0]      g_rd_s;
  logic [XLEN-1:0]    g_data_s;
  logic               g_rd_busy_s;
  logic               issue_acc_s;
  logic               haz_s;

  riscv_rr_arbiter #(.NUM_SRC(NUM_SRC), .PW(PW)) u_arb (
    .req   (wb_valid),
    .ptr   (rr_ptr_r),
    .grant (grant_s),
    .idx   (gidx_s),
    .valid (hs_s)
  );

  assign wb_ready = grant_s;
  assign g_rd_s   = wb_rd[gidx_s*AW +: AW];
  assign g_data_s = wb_data[gidx_s*XLEN +: XLEN];

  // Hazard detection, scoreboard update and round-robin pointer advance.
  always_comb begin
    haz_s = (|(busy_r & reg_mask(issue_rs1))) | (|(busy_r & reg_mask(issue_rs2)))
          | (issue_rd_we & (|(busy_r & reg_mask(issue_rd))));
    issue_stall = issue_valid & haz_s;
    issue_acc_s = issue_valid & ~haz_s & issue_rd_we & (issue_rd != {AW{1'b0}});
    g_rd_busy_s = |(busy_r & reg_mask(g_rd_s));
    busy_next_s = busy_r;
    rr_ptr_next_s = rr_ptr_r;
    if (hs_s) begin
      busy_next_s = busy_next_s & ~reg_mask(g_rd_s);
      if (gidx_s == PW'(NUM_SRC - 1)) begin
        rr_ptr_next_s = {PW{1'b0}};
      end else begin
        rr_ptr_next_s = gidx_s + PW'(1);
      end
    end else begin
      rr_ptr_next_s = rr_ptr_r;
    end
    // An issue to a different rd in the same cycle keeps its set alongside the clear.
    if (issue_acc_s) begin
      busy_next_s = busy_next_s | reg_mask(issue_rd);
    end else begin
      busy_next_s = busy_next_s;
    end
  end

  // State and registered regfile write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r         <= {NREGS{1'b0}};
      rr_ptr_r       <= {PW{1'b0}};
      sb_err_r       <= 1'b0;
      reg_write_en_r <= 1'b0;
      rd_r           <= {AW{1'b0}};
      data_r         <= {XLEN{1'b0}};
    end else begin
      busy_r   <= busy_next_s;
      rr_ptr_r <= rr_ptr_next_s;
      sb_err_r <= sb_err_r | (hs_s & (g_rd_s != {AW{1'b0}}) & ~g_rd_busy_s);
      if (hs_s) begin
        reg_write_en_r <= (g_rd_s != {AW{1'b0}});
        rd_r           <= g_rd_s;
        data_r         <= g_data_s;
      end else begin
        reg_write_en_r <= 1'b0;
        rd_r           <= {AW{1'b0}};
        data_r         <= {XLEN{1'b0}};
      end
    end
  end

  assign busy_vec     = busy_r;
  assign sb_err       = sb_err_r;
  assign reg_write_en = reg_write_en_r;
  assign rd           = rd_r;
  assign data_to_reg  = data_r;

endmodule

// File: tb/tb_riscv_wb_scheduler.sv
// Directed bench for riscv_wb_scheduler: hazards, round-robin order, x0 and error cases.
module tb_riscv_wb_scheduler;
  import riscv_pkg::*;

  logic        clk;
  logic        rst;
  logic        issue_valid;
  logic [4:0]  issue_rs1;
  logic [4:0]  issue_rs2;
  logic [4:0]  issue_rd;
  logic        issue_rd_we;
  logic        issue_stall;
  logic [2:0]  wb_valid;
  logic [14:0] wb_rd;
  logic [95:0] wb_data;
  logic [2:0]  wb_ready;
  logic        reg_write_en;
  logic [4:0]  rd;
  logic [31:0] data_to_reg;
  logic [31:0] busy_vec;
  logic        sb_err;

  int checks = 0;
  int passes = 0;

  riscv_wb_scheduler #(.NUM_SRC(3), .XLEN(32), .AW(5)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rd(issue_rd), .issue_rd_we(issue_rd_we), .issue_stall(issue_stall),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_ready(wb_ready),
    .reg_write_en(reg_write_en), .rd(rd), .data_to_reg(data_to_reg),
    .busy_vec(busy_vec), .sb_err(sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    issue_valid = 1'b0; issue_rs1 = 5'd0; issue_rs2 = 5'd0;
    issue_rd = 5'd0; issue_rd_we = 1'b0;
    wb_valid = 3'b000; wb_rd = 15'd0; wb_data = 96'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_write(input logic [4:0] r);
    issue_valid = 1'b1; issue_rd = r; issue_rd_we = 1'b1;
    issue_rs1 = 5'd0; issue_rs2 = 5'd0;
    tick();
    issue_valid = 1'b0; issue_rd = 5'd0; issue_rd_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    #12;
    checks++; if (busy_vec !== 32'h0) $display("FAIL rst_busy: got %h want %h", busy_vec, 32'h0); else passes++;
    checks++; if (reg_write_en !== 1'b0) $display("FAIL rst_we: got %b want 0", reg_write_en); else passes++;
    checks++; if (rd !== 5'd0) $display("FAIL rst_rd: got %0d want 0", rd); else passes++;
    checks++; if (sb_err !== 1'b0) $display("FAIL rst_sberr: got %b want 0", sb_err); else passes++;
    checks++; if (wb_ready !== 3'b000) $display("FAIL rst_ready: got %b want 000", wb_ready); else passes++;
    tick();
    rst = 1'b0;
    issue_write(5'd2);
    issue_write(5'd5);
    checks++; if (busy_vec !== 32'h0000_0024) $display("FAIL pre_busy: got %h want %h", busy_vec, 32'h24); else passes++;
    wb_valid = 3'b010; wb_rd[SRC_LSU*5 +: 5] = 5'd9; wb_data[SRC_LSU*32 +: 32] = 32'h1111_2222;
    tick();
    checks++; if (reg_write_en !== 1'b1) $display("FAIL pre_we: got %b want 1", reg_write_en); else passes++;
    checks++; if (sb_err !== 1'b1) $display("FAIL pre_sberr: got %b want 1", sb_err); else passes++;
    // Reset lands mid-cycle while a write is on the port and LSU is still requesting.
    wb_rd[SRC_LSU*5 +: 5] = 5'd2;
    #2 rst = 1'b1;
    #1;
    checks++; if (busy_vec !== 32'h0) $display("FAIL mid_busy: got %h want 0", busy_vec); else passes++;
    checks++; if (reg_write_en !== 1'b0) $display("FAIL mid_we: got %b want 0", reg_write_en); else passes++;
    checks++; if (rd !== 5'd0 || data_to_reg !== 32'h0) $display("FAIL mid_rd: got %0d/%h want 0/0", rd, data_to_reg); else passes++;
    checks++; if (sb_err !== 1'b0) $display("FAIL mid_sberr: got %b want 0", sb_err); else passes++;
    wb_valid = 3'b000;
    tick();
    rst = 1'b0;
    #1;
    checks++; if (wb_ready !== 3'b000) $display("FAIL rel_ready: got %b want 000", wb_ready); else passes++;
    wb_valid = 3'b111;
    #1;
    checks++; if (wb_ready !== 3'b001) $display("FAIL rel_ptr: got %b want 001", wb_ready); else passes++;
    idle_inputs();
  endtask

  task automatic test_raw();
    issue_valid = 1'b1; issue_rd = 5'd5; issue_rd_we = 1'b1;
    #1;
    checks++; if (issue_stall !== 1'b0) $display("FAIL raw_first_stall: got %b want 0", issue_stall); else passes++;
    tick();
    checks++; if (busy_vec !== 32'h20) $display("FAIL raw_busy: got %h want %h", busy_vec, 32'h20); else passes++;
    issue_rs1 = 5'd5; issue_rd = 5'd0; issue_rd_we = 1'b0;
    wb_valid = 3'b010; wb_rd[SRC_LSU*5 +: 5] = 5'd5; wb_data[SRC_LSU*32 +: 32] = 32'hDEAD_BEEF;
    #1;
    checks++; if (issue_stall !== 1'b1) $display("FAIL raw_stall: got %b want 1", issue_stall); else passes++;
    checks++; if (wb_ready !== 3'b010) $display("FAIL raw_ready: got %b want 010", wb_ready); else passes++;
    tick();
    checks++; if (busy_vec !== 32'h0 || issue_stall !== 1'b0) $display("FAIL raw_clear: got busy %h stall %b want 0 0", busy_vec, issue_stall); else passes++;
    checks++; if (reg_write_en !== 1'b1 || rd !== 5'd5 || data_to_reg !== 32'hDEAD_BEEF)
      $display("FAIL raw_write: got we %b rd %0d data %h want 1 5 deadbeef", reg_write_en, rd, data_to_reg); else passes++;
    idle_inputs();
    tick();
    checks++; if (reg_write_en !== 1'b0 || rd !== 5'd0 || data_to_reg !== 32'h0)
      $display("FAIL raw_idle: got we %b rd %0d data %h want 0 0 0", reg_write_en, rd, data_to_reg); else passes++;
  endtask

  task automatic test_waw();
    issue_valid = 1'b1; issue_rd = 5'd7; issue_rd_we = 1'b1;
    tick();
    checks++; if (busy_vec !== 32'h80 || issue_stall !== 1'b1) $display("FAIL waw_stall: got busy %h stall %b want 80 1", busy_vec, issue_stall); else passes++;
    tick();
    checks++; if (busy_vec !== 32'h80 || issue_stall !== 1'b1) $display("FAIL waw_hold: got busy %h stall %b want 80 1", busy_vec, issue_stall); else passes++;
    wb_valid = 3'b100; wb_rd[SRC_MDU*5 +: 5] = 5'd7; wb_data[SRC_MDU*32 +: 32] = 32'h0000_0077;
    #1;
    checks++; if (wb_ready !== 3'b100 || issue_stall !== 1'b1) $display("FAIL waw_wb: got ready %b stall %b want 100 1", wb_ready, issue_stall); else passes++;
    tick();
    checks++; if (issue_stall !== 1'b0 || busy_vec !== 32'h0 || rd !== 5'd7) $display("FAIL waw_release: got stall %b busy %h rd %0d want 0 0 7", issue_stall, busy_vec, rd); else passes++;
    wb_valid = 3'b000;
    tick();
    checks++; if (busy_vec !== 32'h80) $display("FAIL waw_reissue: got %h want 80", busy_vec); else passes++;
    idle_inputs();
    wb_valid = 3'b100; wb_rd[SRC_MDU*5 +: 5] = 5'd7;
    tick();
    wb_valid = 3'b000;
    checks++; if (busy_vec !== 32'h0 || sb_err !== 1'b0) $display("FAIL waw_cleanup: got busy %h err %b want 0 0", busy_vec, sb_err); else passes++;
    idle_inputs();
  endtask

  task automatic test_round_robin();
    logic [2:0]  exp_ready [3] = '{3'b001, 3'b010, 3'b100};
    logic [4:0]  exp_rd    [3] = '{5'd1, 5'd2, 5'd3};
    logic [31:0] exp_data  [3] = '{32'hA1, 32'hA2, 32'hA3};
    logic [31:0] exp_busy  [3] = '{32'h0C, 32'h08, 32'h00};
    issue_write(5'd1);
    issue_write(5'd2);
    issue_write(5'd3);
    checks++; if (busy_vec !== 32'h0E) $display("FAIL rr_busy: got %h want 0e", busy_vec); else passes++;
    wb_valid = 3'b111;
    wb_rd = {5'd3, 5'd2, 5'd1};
    wb_data = {32'hA3, 32'hA2, 32'hA1};
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (wb_ready !== exp_ready[i]) $display("FAIL rr_ready%0d: got %b want %b", i, wb_ready, exp_ready[i]); else passes++;
      tick();
      checks++; if (rd !== exp_rd[i] || data_to_reg !== exp_data[i] || busy_vec !== exp_busy[i])
        $display("FAIL rr_write%0d: got rd %0d data %h busy %h want %0d %h %h", i, rd, data_to_reg, busy_vec, exp_rd[i], exp_data[i], exp_busy[i]); else passes++;
    end
    idle_inputs();
    checks++; if (sb_err !== 1'b0) $display("FAIL rr_sberr: got %b want 0", sb_err); else passes++;
  endtask

  task automatic test_x0_error();
    wb_valid = 3'b001; wb_rd[SRC_ALU*5 +: 5] = 5'd0; wb_data[SRC_ALU*32 +: 32] = 32'h55;
    #1;
    checks++; if (wb_ready !== 3'b001) $display("FAIL x0_ready: got %b want 001", wb_ready); else passes++;
    tick();
    checks++; if (reg_write_en !== 1'b0 || sb_err !== 1'b0 || busy_vec !== 32'h0)
      $display("FAIL x0_write: got we %b err %b busy %h want 0 0 0", reg_write_en, sb_err, busy_vec); else passes++;
    idle_inputs();
    wb_valid = 3'b010; wb_rd[SRC_LSU*5 +: 5] = 5'd9; wb_data[SRC_LSU*32 +: 32] = 32'h99;
    #1;
    checks++; if (wb_ready !== 3'b010) $display("FAIL err_ready: got %b want 010", wb_ready); else passes++;
    tick();
    checks++; if (reg_write_en !== 1'b1 || rd !== 5'd9 || sb_err !== 1'b1)
      $display("FAIL err_write: got we %b rd %0d err %b want 1 9 1", reg_write_en, rd, sb_err); else passes++;
    idle_inputs();
    tick();
    tick();
    checks++; if (sb_err !== 1'b1 || reg_write_en !== 1'b0) $display("FAIL err_sticky: got err %b we %b want 1 0", sb_err, reg_write_en); else passes++;
  endtask

  task automatic test_same_cycle();
    issue_write(5'd6);
    checks++; if (busy_vec !== 32'h40) $display("FAIL same_pre: got %h want 40", busy_vec); else passes++;
    issue_valid = 1'b1; issue_rd = 5'd4; issue_rd_we = 1'b1; issue_rs1 = 5'd1; issue_rs2 = 5'd2;
    wb_valid = 3'b100; wb_rd[SRC_MDU*5 +: 5] = 5'd6; wb_data[SRC_MDU*32 +: 32] = 32'h66;
    #1;
    checks++; if (issue_stall !== 1'b0 || wb_ready !== 3'b100) $display("FAIL same_comb: got stall %b ready %b want 0 100", issue_stall, wb_ready); else passes++;
    tick();
    checks++; if (busy_vec !== 32'h10) $display("FAIL same_busy: got %h want 10", busy_vec); else passes++;
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_raw();
    test_waw();
    test_round_robin();
    test_x0_error();
    test_same_cycle();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
